// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: FSM encoding and word packing constants.
package camera_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 13;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DONE     = 3'd4
  } cap_state_e;

endpackage

// File: rtl/dvp_sync_edge.sv
// Multi-flop synchronizer for one asynchronous DVP control line, with rise/fall pulse detection.
module dvp_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   level;

  // Synchronizer chain plus one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~dly_q;
  assign fall_c = ~level & dly_q;

endmodule

// File: rtl/camera_dvp_capture.sv
// Captures one DVP camera frame into the frame RAM as little-endian packed 32-bit words.
module camera_dvp_capture #(
  parameter int unsigned ADDR_W      = camera_pkg::DEFAULT_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_D,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [31:0]       RAM_WDATA,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic              OVERFLOW
);

  import camera_pkg::*;

  localparam int unsigned CW = ADDR_W + 1;

  logic pclk_rise, pclk_fall_unused, vs_rise, vs_fall;

  dvp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pclk_sync (
    .clk(HCLK), .rst_n(HRESETn), .din(CAM_PCLK),
    .rise_c(pclk_rise), .fall_c(pclk_fall_unused)
  );

  dvp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync_sync (
    .clk(HCLK), .rst_n(HRESETn), .din(CAM_VSYNC),
    .rise_c(vs_rise), .fall_c(vs_fall)
  );

  // HREF/D pipeline matches the PCLK chain depth so data lines up with pclk_rise
  logic [SYNC_STAGES-1:0]      href_q;
  logic [SYNC_STAGES-1:0][7:0] d_q;
  logic                        href_s;
  logic [7:0]                  d_s;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      href_q <= '0;
      d_q    <= '0;
    end else begin
      href_q <= {href_q[SYNC_STAGES-2:0], CAM_HREF};
      d_q    <= {d_q[SYNC_STAGES-2:0], CAM_D};
    end
  end

  assign href_s = href_q[SYNC_STAGES-1];
  assign d_s    = d_q[SYNC_STAGES-1];

  cap_state_e          state_q, state_n;
  logic [LANE_W-1:0]   lane_q, lane_n;
  logic [WORD_W-1:0]   word_q, word_n;
  logic                we_q, we_n;
  logic [ADDR_W-1:0]   waddr_q, waddr_n;
  logic [WORD_W-1:0]   wdata_q, wdata_n;
  logic [CW-1:0]       count_q, count_n;
  logic                ovf_q, ovf_n;
  logic                ready_q, ready_n;
  logic                armed_q, armed_n;
  logic                full;

  assign full = count_q[ADDR_W];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_n;
      lane_q  <= lane_n;
      word_q  <= word_n;
      we_q    <= we_n;
      waddr_q <= waddr_n;
      wdata_q <= wdata_n;
      count_q <= count_n;
      ovf_q   <= ovf_n;
      ready_q <= ready_n;
      armed_q <= armed_n;
    end
  end

  always_comb begin
    state_n = state_q;
    lane_n  = lane_q;
    word_n  = word_q;
    we_n    = 1'b0;
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    count_n = count_q;
    ovf_n   = ovf_q;
    ready_n = 1'b0;
    armed_n = armed_q;

    unique case (state_q)
      ST_IDLE: begin
        // Recapture only after the request has been seen low since the last frame
        if (!DATA_VALID) begin
          armed_n = 1'b1;
        end else if (armed_q) begin
          state_n = ST_WAIT_SOF;
          count_n = '0;
          ovf_n   = 1'b0;
          waddr_n = '0;
          lane_n  = '0;
          word_n  = '0;
        end
      end
      ST_WAIT_SOF: begin
        if (!DATA_VALID)  state_n = ST_IDLE;
        else if (vs_fall) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!DATA_VALID) begin
          state_n = ST_IDLE;
        end else begin
          if (pclk_rise && href_s) begin
            if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
              if (full) begin
                ovf_n   = 1'b1;
                state_n = ST_DONE;
              end else begin
                we_n    = 1'b1;
                waddr_n = count_q[ADDR_W-1:0];
                wdata_n = {d_s, word_q[WORD_W-9:0]};
                count_n = count_q + CW'(1);
              end
              lane_n = '0;
              word_n = '0;
            end else begin
              word_n[{lane_q, 3'b000} +: 8] = d_s;
              lane_n = lane_q + LANE_W'(1);
            end
          end
          if (vs_rise && state_n == ST_CAPTURE) state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Upper lanes of a partial word are already zero
        if (lane_q != '0) begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            we_n    = 1'b1;
            waddr_n = count_q[ADDR_W-1:0];
            wdata_n = word_q;
            count_n = count_q + CW'(1);
          end
          lane_n = '0;
          word_n = '0;
        end
        state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        armed_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_DONE) ready_n = 1'b1;
  end

  assign DATA_READY = ready_q;
  assign RAM_WE     = we_q;
  assign RAM_WADDR  = waddr_q;
  assign RAM_WDATA  = wdata_q;
  assign WORD_COUNT = count_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_camera_dvp_capture.sv
// Self-checking bench for camera_dvp_capture: table-driven frames, corner sequences, random frames.
module tb_camera_dvp_capture;

  localparam int unsigned AW  = 7;
  localparam int          CAP = 1 << AW;

  logic          hclk, hresetn, data_valid, data_ready;
  logic          cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_d;
  logic          ram_we, ovf;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [AW:0]   word_count;

  camera_dvp_capture #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .DATA_VALID(data_valid), .DATA_READY(data_ready),
    .CAM_PCLK(cam_pclk), .CAM_VSYNC(cam_vsync), .CAM_HREF(cam_href), .CAM_D(cam_d),
    .RAM_WE(ram_we), .RAM_WADDR(ram_waddr), .RAM_WDATA(ram_wdata),
    .WORD_COUNT(word_count), .OVERFLOW(ovf)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    int lines; int bpl; logic [7:0] start;
    int exp_words; logic [31:0] exp_last; int exp_count; logic exp_ovf;
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] acc_q[$];
  int         ready_cnt = 0;
  int         ready_base = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Record every RAM write and DATA_READY pulse away from the active edge
  always @(negedge hclk) begin
    wr_t e;
    if (ram_we) begin
      e.addr = ram_waddr;
      e.data = ram_wdata;
      wr_q.push_back(e);
    end
    if (data_ready) ready_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge hclk);
    cam_vsync = vs; cam_href = hr; cam_d = d; cam_pclk = 1'b0;
    repeat (3) @(negedge hclk);
    cam_pclk = 1'b1;
    repeat (3) @(negedge hclk);
  endtask

  task automatic begin_case();
    wr_q.delete();
    acc_q.delete();
    ready_base = ready_cnt;
  endtask

  task automatic end_case();
    data_valid = 1'b0;
    repeat (5) @(negedge hclk);
  endtask

  // Drives a full frame: inter-frame VSYNC high, SOF, lines with blanking, EOF
  task automatic send_frame(input int lines, input int bpl, input logic [7:0] start,
                            input bit rnd, input bit record, output int early);
    logic [7:0] v;
    int n = 0;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < bpl; b++) begin
        if (rnd && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 8'($urandom));
        v = rnd ? 8'($urandom) : start + 8'(n);
        tick(1'b0, 1'b1, v);
        if (record) acc_q.push_back(v);
        n++;
      end
      repeat (2) tick(1'b0, 1'b0, 8'($urandom));
    end
    early = ready_cnt - ready_base;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (10) @(negedge hclk);
  endtask

  // Reference: accepted bytes packed little-endian, zero-padded, truncated at RAM capacity
  task automatic check_frame(input string tag, input int exp_ready);
    logic [31:0] w;
    int nb, nw, nexp;
    nb = acc_q.size();
    nw = (nb + 3) / 4;
    nexp = (nw > CAP) ? CAP : nw;
    check({tag, " writes"}, wr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < nb) w[8 * k +: 8] = acc_q[4 * i + k];
      check($sformatf("%s addr%0d", tag, i), 32'(wr_q[i].addr), i);
      check($sformatf("%s data%0d", tag, i), wr_q[i].data, w);
    end
    check({tag, " count"}, 32'(word_count), nexp);
    check({tag, " ovf"}, 32'(ovf), 32'(nw > CAP));
    check({tag, " ready"}, ready_cnt - ready_base, exp_ready);
  endtask

  vec_t tbl[6];
  int   early;

  initial begin
    tbl[0] = '{8, 16,  8'h00, 32,  32'h7F7E7D7C, 32,  1'b0};
    tbl[1] = '{3, 5,   8'h00, 4,   32'h000E0D0C, 4,   1'b0};
    tbl[2] = '{1, 1,   8'hA5, 1,   32'h000000A5, 1,   1'b0};
    tbl[3] = '{2, 6,   8'h10, 3,   32'h1B1A1918, 3,   1'b0};
    tbl[4] = '{0, 0,   8'h00, 0,   32'h00000000, 0,   1'b0};
    tbl[5] = '{3, 172, 8'h00, 128, 32'hFFFEFDFC, 128, 1'b1};

    hresetn = 1'b0; data_valid = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    repeat (4) @(negedge hclk);
    check("rst ready", 32'(data_ready), 0);
    check("rst we", 32'(ram_we), 0);
    check("rst waddr", 32'(ram_waddr), 0);
    check("rst wdata", ram_wdata, 0);
    check("rst count", 32'(word_count), 0);
    check("rst ovf", 32'(ovf), 0);
    hresetn = 1'b1;
    repeat (3) @(negedge hclk);

    for (int t = 0; t < 6; t++) begin
      begin_case();
      data_valid = 1'b1;
      send_frame(tbl[t].lines, tbl[t].bpl, tbl[t].start, 1'b0, 1'b1, early);
      check($sformatf("tbl%0d nwr", t), wr_q.size(), tbl[t].exp_words);
      if (tbl[t].exp_words > 0 && wr_q.size() > 0)
        check($sformatf("tbl%0d last", t), wr_q[wr_q.size() - 1].data, tbl[t].exp_last);
      check($sformatf("tbl%0d wc", t), 32'(word_count), tbl[t].exp_count);
      check($sformatf("tbl%0d of", t), 32'(ovf), 32'(tbl[t].exp_ovf));
      check($sformatf("tbl%0d early_ready", t), early, 32'(tbl[t].exp_ovf));
      check_frame($sformatf("tbl%0d", t), 1);
      end_case();
    end

    // Request raised mid-frame: that frame is skipped entirely
    begin_case();
    tick(1'b0, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 1'b1, 8'hEE);
    data_valid = 1'b1;
    repeat (6) tick(1'b0, 1'b1, 8'hEE);
    repeat (2) tick(1'b0, 1'b0, 8'hEE);
    check("midframe nowrite", wr_q.size(), 0);
    send_frame(2, 8, 8'h20, 1'b0, 1'b1, early);
    check("midframe word0", wr_q.size() > 0 ? wr_q[0].data : 32'hX, 32'h23222120);
    check_frame("midframe", 1);
    end_case();

    // Abort after 10 words
    begin_case();
    data_valid = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 42; i++) begin
      tick(1'b0, 1'b1, 8'(i + 8'h30));
      if (i < 40) acc_q.push_back(8'(i + 8'h30));
    end
    @(negedge hclk);
    data_valid = 1'b0;
    repeat (6) tick(1'b0, 1'b1, 8'h99);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (10) @(negedge hclk);
    check_frame("abort", 0);
    end_case();

    // Byte arriving together with end-of-frame is still captured
    begin_case();
    data_valid = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 8'(8'h50 + i));
      acc_q.push_back(8'(8'h50 + i));
    end
    @(negedge hclk);
    cam_href = 1'b1; cam_d = 8'h54; cam_pclk = 1'b0; cam_vsync = 1'b0;
    repeat (3) @(negedge hclk);
    cam_pclk = 1'b1; cam_vsync = 1'b1;
    acc_q.push_back(8'h54);
    repeat (3) @(negedge hclk);
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (10) @(negedge hclk);
    check_frame("simul", 1);
    check("simul last", wr_q.size() == 2 ? wr_q[1].data : 32'hX, 32'h00000054);
    end_case();

    // DATA_VALID held high after DONE: no recapture until it drops
    begin_case();
    data_valid = 1'b1;
    send_frame(1, 8, 8'h60, 1'b0, 1'b1, early);
    check_frame("hold1", 1);
    begin_case();
    send_frame(2, 8, 8'h70, 1'b0, 1'b0, early);
    check("hold nowrite", wr_q.size(), 0);
    check("hold noready", ready_cnt - ready_base, 0);
    data_valid = 1'b0;
    repeat (3) @(negedge hclk);
    data_valid = 1'b1;
    begin_case();
    send_frame(1, 12, 8'h80, 1'b0, 1'b1, early);
    check_frame("hold2", 1);
    end_case();

    // Asynchronous reset in the middle of a frame
    begin_case();
    data_valid = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 13; i++) tick(1'b0, 1'b1, 8'(i));
    #2 hresetn = 1'b0;
    #1;
    check("arst count", 32'(word_count), 0);
    check("arst waddr", 32'(ram_waddr), 0);
    check("arst wdata", ram_wdata, 0);
    check("arst we", 32'(ram_we), 0);
    @(negedge hclk);
    hresetn = 1'b1;
    begin_case();
    repeat (8) tick(1'b0, 1'b1, 8'hCC);
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    check("arst nowrite", wr_q.size(), 0);
    begin_case();
    send_frame(2, 10, 8'h90, 1'b0, 1'b1, early);
    check_frame("arst", 1);
    end_case();

    // Random frames with HREF gaps against the packing model
    for (int r = 0; r < 6; r++) begin
      begin_case();
      data_valid = 1'b1;
      send_frame($urandom_range(0, 5), $urandom_range(0, 30), 8'h00, 1'b1, 1'b1, early);
      check_frame($sformatf("rnd%0d", r), 1);
      end_case();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_dvp_capture.md
Name: camera_dvp_capture

Overview:
Write-side companion of the AHB camera peripheral. While the AHB side's capture request (DATA_VALID) is high, this block captures one full frame from the camera's 8-bit DVP port (PCLK/VSYNC/HREF/D) into the 8K x 32 frame RAM. It packs bytes into 32-bit words and drives the RAM write port. When the frame is stored it pulses DATA_READY, which clears the AHB RAM-state bit. All logic runs on HCLK; the DVP inputs are oversampled.

Parameters:
ADDR_W, 13, RAM word-address width; capacity = 2**ADDR_W words.
SYNC_STAGES, 2, synchronizer depth for all DVP inputs (legal range 2-3).

Ports:
HCLK  in  1  system clock; must be at least 4x CAM_PCLK.
HRESETn  in  1  reset, asynchronous, active-low.
DATA_VALID  in  1  capture request level from the AHB camera peripheral.
DATA_READY  out  1  one-HCLK pulse: frame stored or capture aborted on overflow.
CAM_PCLK  in  1  camera pixel clock, asynchronous to HCLK.
CAM_VSYNC  in  1  frame sync, active high between frames.
CAM_HREF  in  1  line-valid qualifier, active high.
CAM_D  in  8  pixel byte.
RAM_WE  out  1  RAM write strobe, one cycle per word.
RAM_WADDR  out  ADDR_W  RAM word address.
RAM_WDATA  out  32  packed word.
WORD_COUNT  out  ADDR_W+1  words written in the current or last frame.
OVERFLOW  out  1  sticky flag: frame exceeded RAM capacity.

Behaviour:
- Reset values: DATA_READY=0, RAM_WE=0, RAM_WADDR=0, RAM_WDATA=0, WORD_COUNT=0, OVERFLOW=0, FSM=IDLE, byte lane=0.
- Input synchronization:
  - CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_D pass through SYNC_STAGES flops, all in the same pipeline.
  - A one-cycle pclk_rise is derived from the last stage vs. one extra delayed flop.
  - vs_rise and vs_fall are derived the same way from VSYNC.
  - Data and HREF are sampled from the same stage as pclk_rise.
- FSM states: IDLE, WAIT_SOF, CAPTURE, FLUSH, DONE.
- IDLE: if DATA_VALID=1, go to WAIT_SOF. On entry to WAIT_SOF: clear WORD_COUNT, OVERFLOW, RAM_WADDR and the byte lane.
- WAIT_SOF: wait for vs_fall (start of frame), then go to CAPTURE. A frame already in progress at request time is skipped.
- CAPTURE, on each pclk_rise with HREF=1:
  - Byte goes into lane k: lane 0 -> bits [7:0], lane 3 -> [31:24] (little-endian); k increments.
  - On the 4th byte: next cycle RAM_WE=1 with the full word, RAM_WADDR=current address. The address then increments, WORD_COUNT increments, and k returns to 0.
- CAPTURE, on vs_rise (end of frame): go to FLUSH.
- FLUSH: if k!=0, issue one write of the partial word with unused upper lanes = 0 and count it. Then go to DONE.
- DONE: DATA_READY=1 for exactly one cycle, then IDLE.
- Overflow: if a word would be written when WORD_COUNT = 2**ADDR_W:
  - The write is suppressed and OVERFLOW=1.
  - The FSM goes directly to DONE; DATA_READY still pulses.
  - RAM_WADDR never wraps.
- Abort: if DATA_VALID falls in WAIT_SOF or CAPTURE, go to IDLE immediately. No further writes, no DATA_READY. WORD_COUNT and OVERFLOW hold their values.
- Simultaneous pclk_rise and vs_rise: the byte is accepted first, then FLUSH.
- HREF low: bytes are ignored. Lane position carries across lines; lines need not be multiples of 4 bytes.
- Writes are at most one per 4 pclk_rise, so there is no RAM backpressure.
- Latency: the 4th byte's pclk_rise at the sync output produces RAM_WE in the following cycle.
- DATA_VALID held high after DONE: no recapture until DATA_VALID has been seen low in IDLE. A rearm flag enforces this.
- Async reset mid-frame: all state returns to reset values; the next capture resynchronizes at the next vs_fall.

Decomposition:
- Shared package camera_pkg: FSM state encoding (IDLE=0 .. DONE=4), BYTES_PER_WORD=4, default ADDR_W=13, which matches the AHB-side ADDR width.
- Sub-module dvp_sync_edge: parameterized synchronizer plus rise/fall detector, instantiated for PCLK and VSYNC. The HREF/D pipeline sits alongside in the top.

Test Plan:
- Frame 8 lines x 16 bytes, D = incrementing 0x00.. -> 32 writes, addr 0..31, word0=0x03020100, word31=0x7F7E7D7C, WORD_COUNT=32, one DATA_READY pulse, OVERFLOW=0.
- 3 lines x 5 bytes (15 bytes) -> 4 writes; last word=0x000E0D0C (zero-padded), WORD_COUNT=4.
- Request asserted mid-frame (VSYNC low, HREF toggling) -> no writes until after next VSYNC high->low; first word is that frame's bytes 0-3.
- Frame of 8193 words with ADDR_W=13 -> last write addr 8191, OVERFLOW=1, DATA_READY pulses immediately after the rejected word; no write to addr 0.
- DATA_VALID dropped after 10 words -> FSM IDLE within 1 cycle, no more RAM_WE, no DATA_READY, WORD_COUNT=10.
- DATA_VALID held high after DONE -> no second capture; after DATA_VALID low then high, second frame captured from addr 0.
